// File: rtl/shift_register_pkg.sv
// Shared types and helpers for the parametrised shift register.
package shift_register_pkg;

  // Action selected on a tick edge.
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  // Clear group that owns a given stage.
  function automatic int unsigned group_of(input int unsigned stage,
                                           input int unsigned groups);
    return stage % groups;
  endfunction

endpackage : shift_register_pkg

// File: rtl/tick_divider.sv
// Free-running divider producing the action tick and its registered copy.
module tick_divider #(
  parameter int unsigned TAP = 22
) (
  input  logic clk,
  input  logic rst,
  input  logic bypass_i,
  output logic tick_o,
  output logic tick_c
);

  localparam int unsigned CNT_W = TAP + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Counter wraps naturally; tick fires on all-ones or when bypassed.
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    tick_c = (&cnt_q) | bypass_i;
    tick_d = tick_c;
  end

  // Divider state and registered tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule : tick_divider

// File: rtl/shift_register_param.sv
// Serial/parallel shift register with rotate, load, grouped clears and fill tracking.
module shift_register_param
  import shift_register_pkg::*;
#(
  parameter  int unsigned WIDTH  = 8,
  parameter  int unsigned GROUPS = 4,
  parameter  int unsigned TAP    = 22,
  localparam int unsigned FILL_W = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              div_bypass_i,
  input  logic [1:0]        mode_i,
  input  logic              rot_i,
  input  logic              ser_i,
  input  logic [WIDTH-1:0]  load_i,
  input  logic [GROUPS-1:0] clr_i,
  output logic [WIDTH-1:0]  q_o,
  output logic              ser_o,
  output logic              tick_o,
  output logic [FILL_W-1:0] fill_o,
  output logic              full_o
);

  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIDTH);

  logic              tick_c;
  mode_t             mode_c;
  logic [WIDTH-1:0]  clr_mask_c;
  logic [WIDTH-1:0]  shift_c;
  logic [FILL_W-1:0] fill_nxt_c;
  logic              in_up_c;
  logic              in_dn_c;

  logic [WIDTH-1:0]  q_q, q_d;
  logic              ser_q, ser_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              full_q, full_d;

  // Action tick source.
  tick_divider #(
    .TAP (TAP)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .bypass_i (div_bypass_i),
    .tick_o   (tick_o),
    .tick_c   (tick_c)
  );

  assign mode_c = mode_t'(mode_i);

  // Per-stage clear mask: each stage follows its group's clear bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_clr
    assign clr_mask_c[i] = clr_i[group_of(i, GROUPS)];
  end

  // Incoming bit for each shift direction: wrap-around or serial input.
  always_comb begin
    in_up_c = rot_i ? q_q[WIDTH-1] : ser_i;
    in_dn_c = rot_i ? q_q[0]       : ser_i;
  end

  // Tick-qualified datapath, serial-out and fill update before clears.
  always_comb begin
    shift_c    = q_q;
    ser_d      = ser_q;
    fill_nxt_c = fill_q;
    if (tick_c) begin
      unique case (mode_c)
        MODE_HOLD: begin
          shift_c = q_q;
        end
        MODE_UP: begin
          shift_c = {q_q[WIDTH-2:0], in_up_c};
          ser_d   = q_q[WIDTH-1];
          if (!rot_i && (fill_q != FILL_MAX)) begin
            fill_nxt_c = fill_q + FILL_W'(1);
          end
        end
        MODE_DOWN: begin
          shift_c = {in_dn_c, q_q[WIDTH-1:1]};
          ser_d   = q_q[0];
          if (!rot_i && (fill_q != FILL_MAX)) begin
            fill_nxt_c = fill_q + FILL_W'(1);
          end
        end
        MODE_LOAD: begin
          shift_c    = load_i;
          fill_nxt_c = FILL_MAX;
        end
        default: begin
          shift_c = q_q;
        end
      endcase
    end
  end

  // Clears act every clock, overriding only the stages they own and the fill count.
  always_comb begin
    q_d    = shift_c & ~clr_mask_c;
    fill_d = (|clr_i) ? '0 : fill_nxt_c;
    full_d = (fill_d == FILL_MAX);
  end

  // Register state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q    <= '0;
      ser_q  <= 1'b0;
      fill_q <= '0;
      full_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      ser_q  <= ser_d;
      fill_q <= fill_d;
      full_q <= full_d;
    end
  end

  assign q_o    = q_q;
  assign ser_o  = ser_q;
  assign fill_o = fill_q;
  assign full_o = full_q;

endmodule : shift_register_param
